// File: rtl/multipath_scan_ctrl.sv
// Scan controller that steps a multipath selector through 32 paths. It either learns each
// path's result as a golden reference or checks it against the stored reference within a tolerance.
module multipath_scan_ctrl #(
  parameter int unsigned SETTLE_CYCLES  = 4,    // must be >= 1
  parameter int unsigned TIMEOUT_CYCLES = 1024  // must be >= 1
) (
  input  logic        clk250,
  input  logic        rst,
  input  logic        start,
  input  logic        learn,
  input  logic [15:0] tol,
  output logic [4:0]  path_sel,
  input  logic [31:0] path_result,
  input  logic        path_fin,
  output logic        busy,
  output logic        done,
  output logic        trojan,
  output logic [31:0] flag_vec,
  output logic [31:0] timeout_vec,
  output logic [31:0] last_result
);

  localparam int unsigned CntMax = (SETTLE_CYCLES > TIMEOUT_CYCLES) ? SETTLE_CYCLES
                                                                    : TIMEOUT_CYCLES;
  localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;
  localparam logic [CntW-1:0] SettleLoad  = CntW'(SETTLE_CYCLES - 1);
  localparam logic [CntW-1:0] TimeoutLoad = CntW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle, StSelect, StSettle, StWaitFin, StCapture, StNext, StDone
  } state_e;

  state_e          state_q, state_d;
  logic [4:0]      idx_q;
  logic [CntW-1:0] cnt_q;
  logic            learn_q;
  logic [15:0]     tol_q;
  logic [31:0]     flag_vec_q;
  logic [31:0]     timeout_vec_q;
  logic            trojan_q;
  logic [31:0]     last_result_q;

  // Golden references; not reset, so they power up to zero from configuration only.
  logic [31:0]     ref_mem [32];

  logic [31:0]     ref_sel;
  logic [32:0]     abs_diff;
  logic            mismatch;

  always_comb begin
    ref_sel  = ref_mem[idx_q];
    abs_diff = (last_result_q >= ref_sel) ? ({1'b0, last_result_q} - {1'b0, ref_sel})
                                          : ({1'b0, ref_sel} - {1'b0, last_result_q});
    mismatch = abs_diff > {17'd0, tol_q};
  end

  always_ff @(posedge clk250) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (start) state_d = StSelect;
      StSelect:  state_d = StSettle;
      StSettle:  if (cnt_q == '0) state_d = StWaitFin;
      StWaitFin: begin
        if (path_fin) begin
          state_d = StCapture;
        end else if (cnt_q == '0) begin
          state_d = StNext;
        end
      end
      StCapture: state_d = StNext;
      StNext:    state_d = (idx_q == 5'd31) ? StDone : StSelect;
      StDone:    state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_comb begin
    busy = (state_q != StIdle);
    done = (state_q == StDone);
  end

  always_ff @(posedge clk250) begin
    if (rst) begin
      idx_q         <= '0;
      cnt_q         <= '0;
      learn_q       <= 1'b0;
      tol_q         <= '0;
      flag_vec_q    <= '0;
      timeout_vec_q <= '0;
      trojan_q      <= 1'b0;
      last_result_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            learn_q       <= learn;
            tol_q         <= tol;
            flag_vec_q    <= '0;
            timeout_vec_q <= '0;
            idx_q         <= '0;
          end
        end
        StSelect: cnt_q <= SettleLoad;
        StSettle: cnt_q <= (cnt_q == '0) ? TimeoutLoad : cnt_q - 1'b1;
        StWaitFin: begin
          if (path_fin) begin
            last_result_q <= path_result;
          end else if (cnt_q == '0) begin
            timeout_vec_q[idx_q] <= 1'b1;
            if (!learn_q) flag_vec_q[idx_q] <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StCapture: if (!learn_q && mismatch) flag_vec_q[idx_q] <= 1'b1;
        StNext: begin
          // Flags are final by the last NEXT, so trojan is already valid during done.
          if (idx_q != 5'd31) idx_q <= idx_q + 5'd1;
          else                trojan_q <= |flag_vec_q;
        end
        StDone:  ;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk250) begin
    if (!rst && state_q == StCapture && learn_q) begin
      ref_mem[idx_q] <= last_result_q;
    end
  end

  assign path_sel    = idx_q;
  assign trojan      = trojan_q;
  assign flag_vec    = flag_vec_q;
  assign timeout_vec = timeout_vec_q;
  assign last_result = last_result_q;

endmodule
